// File: rtl/vsdminisoc_core.sv
// Fixed-program sequencer: repeatedly sums 1..LIMIT-1 and publishes the result on OUT.
// Optional macro VCO_EDGE_STEP_EN: advance one step per synchronized VCO_IN edge.
module vsdminisoc_core #(
    parameter int WIDTH = 10,
    parameter int LIMIT = 10
) (
    input  logic             REF,
    input  logic             reset,
    input  logic             VCO_IN,
    input  logic             ENb_CP,
    input  logic             ENb_VCO,
    output logic [WIDTH-1:0] OUT
);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ADD   = 3'd1,
        INC   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] idx_next;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_next;
    logic             adv;

`ifdef VCO_EDGE_STEP_EN
    logic sync_meta;
    logic sync_now;
    logic sync_prev;

    // sync_prev lags sync_now by one edge so any VCO_IN transition yields one pulse
    always_ff @(posedge REF or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_now  <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_meta <= VCO_IN;
            sync_now  <= sync_meta;
            sync_prev <= sync_now;
        end
    end

    assign adv = ENb_VCO & ~ENb_CP & (sync_now ^ sync_prev);
`else
    logic unused_vco;

    assign unused_vco = VCO_IN;
    assign adv        = ENb_VCO & ~ENb_CP;
`endif

    always_ff @(posedge REF or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (adv) begin
            case (state)
                INIT:    state_next = ADD;
                ADD:     state_next = INC;
                INC:     state_next = CHECK;
                CHECK:   state_next = (idx == LIMIT_V) ? DONE : ADD;
                DONE:    state_next = INIT;
                default: state_next = INIT;
            endcase
        end
    end

    // Datapath next values; holding when adv is low makes adv act as a register enable
    always_comb begin
        sum_next = sum;
        idx_next = idx;
        out_next = out_q;
        if (adv) begin
            case (state)
                INIT: begin
                    sum_next = '0;
                    idx_next = ONE;
                end
                ADD:     sum_next = sum + idx;
                INC:     idx_next = idx + ONE;
                DONE:    out_next = sum;
                default: ;
            endcase
        end
    end

    always_ff @(posedge REF or negedge reset) begin
        if (!reset) begin
            sum   <= '0;
            idx   <= '0;
            out_q <= '0;
        end else begin
            sum   <= sum_next;
            idx   <= idx_next;
            out_q <= out_next;
        end
    end

    assign OUT = out_q;

endmodule

// File: tb/tb_vsdminisoc_core.sv
// Self-checking bench for vsdminisoc_core: three parameterizations driven in lockstep
// and compared against a step-count model of the published sum.
module tb_vsdminisoc_core;

    logic       REF     = 1'b0;
    logic       reset   = 1'b0;
    logic       VCO_IN  = 1'b0;
    logic       ENb_CP  = 1'b0;
    logic       ENb_VCO = 1'b0;
    logic [9:0] out_a;
    logic [3:0] out_b;
    logic [9:0] out_c;

    int   vectors     = 0;
    int   miscompares = 0;
    int   n_en        = 0;
    logic vco_manual  = 1'b0;
    logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    vsdminisoc_core #(.WIDTH(10), .LIMIT(10)) dut_a (
        .REF(REF), .reset(reset), .VCO_IN(VCO_IN),
        .ENb_CP(ENb_CP), .ENb_VCO(ENb_VCO), .OUT(out_a)
    );
    vsdminisoc_core #(.WIDTH(4), .LIMIT(10)) dut_b (
        .REF(REF), .reset(reset), .VCO_IN(VCO_IN),
        .ENb_CP(ENb_CP), .ENb_VCO(ENb_VCO), .OUT(out_b)
    );
    vsdminisoc_core #(.WIDTH(10), .LIMIT(2)) dut_c (
        .REF(REF), .reset(reset), .VCO_IN(VCO_IN),
        .ENb_CP(ENb_CP), .ENb_VCO(ENb_VCO), .OUT(out_c)
    );

    always #5 REF = ~REF;

    // OUT is zero until one full period of enabled steps has elapsed, then the wrapped sum
    function automatic int exp_out(int lim, int w, int steps);
        int p;
        int s;
        p = 3 * (lim - 1) + 2;
        s = ((lim * (lim - 1)) / 2) % (1 << w);
        return (steps >= p) ? s : 0;
    endfunction

    function automatic logic [23:0] exp_bundle(int steps);
        logic [9:0] a;
        logic [3:0] b;
        logic [9:0] c;
        a = 10'(exp_out(10, 10, steps));
        b = 4'(exp_out(10, 4, steps));
        c = 10'(exp_out(2, 10, steps));
        return {a, b, c};
    endfunction

    // One REF edge: count enabled steps in the model, then settle and refresh VCO_IN
    task automatic tick();
        logic step_ok;
        @(posedge REF);
        if (reset) begin
            step_ok = ENb_VCO & ~ENb_CP;
`ifdef VCO_EDGE_STEP_EN
            step_ok = step_ok & (h2 != h3);
            h3 = h2;
            h2 = h1;
            h1 = VCO_IN;
`endif
            if (step_ok) n_en++;
        end else begin
            n_en = 0;
            h1 = 1'b0;
            h2 = 1'b0;
            h3 = 1'b0;
        end
        #1;
        if (!vco_manual) begin
`ifdef VCO_EDGE_STEP_EN
            VCO_IN = ~VCO_IN;
`else
            VCO_IN = 1'($urandom % 2);
`endif
        end
    endtask

    task automatic restart();
        reset = 1'b0;
        n_en  = 0;
        h1 = 1'b0;
        h2 = 1'b0;
        h3 = 1'b0;
        tick();
        tick();
        ENb_VCO = 1'b1;
        ENb_CP  = 1'b0;
        reset   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ENb_CP  = 1'($urandom % 2);
            ENb_VCO = 1'($urandom % 2);
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== 24'h0) begin
                miscompares++;
                $display("[TB] FAIL reset cycle %0d: out=%0d/%0d/%0d expected 0/0/0", i, out_a, out_b, out_c);
            end
        end
    endtask

    task automatic test_basic_run();
        restart();
        for (int e = 1; e <= 60; e++) begin
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== exp_bundle(n_en)) begin
                miscompares++;
                $display("[TB] FAIL basic edge %0d: out=%0d/%0d/%0d expected bundle %h", e, out_a, out_b, out_c, exp_bundle(n_en));
            end
`ifndef VCO_EDGE_STEP_EN
            if (e == 28 || e == 29 || e == 58) begin
                vectors++;
                if (out_a !== ((e == 28) ? 10'd0 : 10'd45)) begin
                    miscompares++;
                    $display("[TB] FAIL basic timing edge %0d: out=%0d expected %0d", e, out_a, (e == 28) ? 0 : 45);
                end
            end
`endif
        end
    endtask

    task automatic test_hold();
        restart();
        for (int e = 1; e <= 40; e++) begin
            if (e >= 10 && e < 17) begin
                if ($urandom % 2 == 0) ENb_VCO = 1'b0;
                else                   ENb_CP  = 1'b1;
            end else begin
                ENb_VCO = 1'b1;
                ENb_CP  = 1'b0;
            end
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== exp_bundle(n_en)) begin
                miscompares++;
                $display("[TB] FAIL hold edge %0d: out=%0d/%0d/%0d expected bundle %h", e, out_a, out_b, out_c, exp_bundle(n_en));
            end
`ifndef VCO_EDGE_STEP_EN
            if (e == 35 || e == 36) begin
                vectors++;
                if (out_a !== ((e == 35) ? 10'd0 : 10'd45)) begin
                    miscompares++;
                    $display("[TB] FAIL hold timing edge %0d: out=%0d expected %0d", e, out_a, (e == 35) ? 0 : 45);
                end
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        restart();
        for (int e = 1; e <= 44; e++) tick();
        reset = 1'b0;
        #1;
        vectors++;
        if ({out_a, out_b, out_c} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL async clear: out=%0d/%0d/%0d expected 0/0/0", out_a, out_b, out_c);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== 24'h0) begin
                miscompares++;
                $display("[TB] FAIL reset hold %0d: out=%0d/%0d/%0d expected 0/0/0", i, out_a, out_b, out_c);
            end
        end
        reset = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== exp_bundle(n_en)) begin
                miscompares++;
                $display("[TB] FAIL post-reset edge %0d: out=%0d/%0d/%0d expected bundle %h", e, out_a, out_b, out_c, exp_bundle(n_en));
            end
        end
    endtask

    task automatic test_random_enable();
        restart();
        for (int e = 1; e <= 300; e++) begin
            ENb_VCO = ($urandom % 4) != 0;
            ENb_CP  = ($urandom % 4) == 0;
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== exp_bundle(n_en)) begin
                miscompares++;
                $display("[TB] FAIL random edge %0d: out=%0d/%0d/%0d expected bundle %h", e, out_a, out_b, out_c, exp_bundle(n_en));
            end
        end
    endtask

`ifdef VCO_EDGE_STEP_EN
    task automatic test_vco_step();
        vco_manual = 1'b1;
        VCO_IN     = 1'b0;
        restart();
        for (int e = 1; e <= 300; e++) begin
            if (e % 10 == 0) VCO_IN = ~VCO_IN;
            tick();
            vectors++;
            if ({out_a, out_b, out_c} !== exp_bundle(n_en)) begin
                miscompares++;
                $display("[TB] FAIL vco edge %0d: out=%0d/%0d/%0d expected bundle %h", e, out_a, out_b, out_c, exp_bundle(n_en));
            end
        end
        vco_manual = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_run();
        test_hold();
        test_mid_reset();
        test_random_enable();
`ifdef VCO_EDGE_STEP_EN
        test_vco_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
